// File: rtl/regfile_arb_pkg.sv
// Shared constants, FSM state type and address decoder for the register-file write arbiter.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package regfile_arb_pkg;

  localparam int NREQ_C   = 4;
  localparam int NREG_C   = 8;
  localparam int ADDR_W_C = 3;
  localparam int DATA_W_C = 32;

  // ARB: normal arbitration. CLEAR: the cycle in which the bank clear is driven.
  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Register index to one-hot bank write enable.
  function automatic logic [NREG_C-1:0] onehot_dec(input logic [ADDR_W_C-1:0] addr);
    logic [NREG_C-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin grant selection, search starts at rr_ptr and wraps.
// Latency: purely combinational.
// Backpressure: none; ineligible requesters are simply skipped.
module rr_arbiter4 (
  input  logic [3:0] eligible,
  input  logic [1:0] rr_ptr,
  output logic [3:0] grant_oh,
  output logic [1:0] grant_idx,
  output logic       grant_vld
);

  logic [1:0] idx;

  // Walk the four slots from rr_ptr and take the first eligible one.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!grant_vld && eligible[idx]) begin
        grant_vld     = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register bank write port among 4 requesters (round-robin) and sequences bank clears.
// Latency: grant decided in cycle N, ack + bank write strobe registered in N+1; clear one cycle after clr_pend.
// Backpressure: req is level and held until ack; a pending clear pre-empts arbitration for one cycle.
// Optional stall counter output enabled by REGFILE_ARB_STATS_EN.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_C,
  parameter int DATA_W = DATA_W_C,
  parameter int NREG   = NREG_C,
  parameter int ADDR_W = ADDR_W_C
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  input  logic                     clr_req,
  output logic                     clr_done,
  output logic [NREG-1:0]          rf_en,
  output logic [DATA_W-1:0]        rf_d_in,
  output logic                     rf_clear
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  state_e              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic                clr_pend_q, clr_pend_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREG-1:0]     rf_en_q, rf_en_d;
  logic [DATA_W-1:0]   rf_d_in_q, rf_d_in_d;

  logic [NREQ-1:0]     eligible;
  logic [NREQ-1:0]     grant_oh;
  logic [1:0]          grant_idx;
  logic                grant_vld;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // A requester that is being acked this cycle is masked so its still-high req cannot write twice.
  assign eligible = req & ~ack_q;

  rr_arbiter4 u_rr (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Select the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: a pending clear beats arbitration; clr_req pulses while pending merge into it.
  always_comb begin
    state_d    = ARB;
    clr_pend_d = clr_pend_q | clr_req;
    rr_ptr_d   = rr_ptr_q;
    ack_d      = '0;
    rf_en_d    = '0;
    rf_d_in_d  = rf_d_in_q;
    if (clr_pend_q) begin
      state_d    = CLEAR;
      clr_pend_d = 1'b0;
    end else if (grant_vld) begin
      ack_d     = grant_oh;
      rf_en_d   = onehot_dec(sel_addr);
      rf_d_in_d = sel_data;
      rr_ptr_d  = grant_idx + 2'd1;
    end
  end

  // State and bank-side output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ARB;
      clr_pend_q <= 1'b0;
      rr_ptr_q   <= '0;
      ack_q      <= '0;
      rf_en_q    <= '0;
      rf_d_in_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_q      <= ack_d;
      rf_en_q    <= rf_en_d;
      rf_d_in_q  <= rf_d_in_d;
    end
  end

  assign ack      = ack_q;
  assign rf_en    = rf_en_q;
  assign rf_d_in  = rf_d_in_q;
  assign rf_clear = (state_q == CLEAR);
  assign clr_done = (state_q == CLEAR);

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic [NREQ-1:0] taken;
  logic            stall;

  // Count cycles where some requester is asking but is not the one granted (clear cycles included).
  always_comb begin
    taken       = clr_pend_q ? '0 : grant_oh;
    stall       = |(req & ~taken);
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Saturating stall counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req;
  logic [11:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   ack;
  logic         clr_req;
  logic         clr_done;
  logic [7:0]   rf_en;
  logic [31:0]  rf_d_in;
  logic         rf_clear;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .clr_req  (clr_req),
    .clr_done (clr_done),
    .rf_en    (rf_en),
    .rf_d_in  (rf_d_in),
    .rf_clear (rf_clear)
`ifdef REGFILE_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0]  ack;
    logic [7:0]  en;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b1;

  function automatic exp_t mk(input logic [3:0] a, input logic [2:0] addr, input logic [31:0] d);
    exp_t e;
    e.ack = a;
    e.en  = 8'b1 << addr;
    e.d   = d;
    return e;
  endfunction

  task automatic set_rq(input int i, input logic [2:0] a, input logic [31:0] d);
    req_addr[i*3 +: 3]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    clr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Scoreboard: every bank write seen must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && (ack !== 4'b0 || rf_en !== 8'b0)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got ack=%b rf_en=%h d=%h, expected no write", ack, rf_en, rf_d_in);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({ack, rf_en, rf_d_in} !== e) begin
          n_fail++;
          $display("FAIL sb_write: got ack=%b rf_en=%h d=%h, expected ack=%b rf_en=%h d=%h",
                   ack, rf_en, rf_d_in, e.ack, e.en, e.d);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    clr_req = 1'b0;
    req     = 4'hF;
    for (int i = 0; i < 4; i++) set_rq(i, 3'(i + 1), 32'hA000_0000 + 32'(i));
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({ack, rf_en, rf_d_in, rf_clear, clr_done} !== 46'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b rf_en=%h d=%h clr=%b done=%b, expected all 0",
               ack, rf_en, rf_d_in, rf_clear, clr_done);
    end
    sb.push_back(mk(4'b0001, 3'd1, 32'hA000_0000));
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got ack=%b, expected 0001", ack);
    end
    req = '0;
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0 || rf_en !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got ack=%b rf_en=%h, expected 0 0", ack, rf_en);
    end
  endtask

  task automatic test_single_write();
    set_rq(2, 3'd5, 32'hDEAD_BEEF);
    req = 4'b0100;
    sb.push_back(mk(4'b0100, 3'd5, 32'hDEAD_BEEF));
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0100 || rf_en !== 8'h20) begin
      n_fail++;
      $display("FAIL single_write: got ack=%b rf_en=%h, expected 0100 20", ack, rf_en);
    end
    req = '0;
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0 || rf_en !== 8'h00 || rf_d_in !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_drop: got ack=%b rf_en=%h d=%h, expected 0 00 deadbeef", ack, rf_en, rf_d_in);
    end
  endtask

  task automatic test_round_robin();
    int          seq[5];
    logic [2:0]  a[4];
    logic [31:0] d[4];
    seq = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a[i] = 3'(7 - i);
      d[i] = 32'hC0DE_0000 + 32'(i * 17);
      set_rq(i, a[i], d[i]);
    end
    for (int k = 0; k < 5; k++) sb.push_back(mk(4'b1 << seq[k], a[seq[k]], d[seq[k]]));
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (ack !== (4'b1 << seq[k])) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got ack=%b, expected requester %0d", k, ack, seq[k]);
      end
      req = (k == 4) ? 4'b0 : (4'hF & ~ack);
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0 || rf_en !== 8'b0) begin
      n_fail++;
      $display("FAIL rr_idle: got ack=%b rf_en=%h, expected 0 0", ack, rf_en);
    end
  endtask

  task automatic test_clear_priority();
    set_rq(1, 3'd2, 32'h5A5A_0001);
    set_rq(3, 3'd6, 32'h5A5A_0003);
    req     = 4'b0010;
    clr_req = 1'b1;
    sb.push_back(mk(4'b0010, 3'd2, 32'h5A5A_0001));
    @(negedge clk);
    n_checks++;
    if (rf_clear !== 1'b0 || ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL clr_grant_first: got clr=%b ack=%b, expected 0 0010", rf_clear, ack);
    end
    req     = '0;
    clr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rf_clear !== 1'b1 || clr_done !== 1'b1 || ack !== 4'b0 || rf_en !== 8'b0) begin
      n_fail++;
      $display("FAIL clr_cycle: got clr=%b done=%b ack=%b rf_en=%h, expected 1 1 0 0",
               rf_clear, clr_done, ack, rf_en);
    end
    req = 4'b1000;
    sb.push_back(mk(4'b1000, 3'd6, 32'h5A5A_0003));
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b1000 || rf_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_after_grant: got ack=%b clr=%b, expected 1000 0", ack, rf_clear);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_merged_clear();
    int n_clr  = 0;
    int n_done = 0;
    req     = '0;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rf_clear === 1'b1) n_clr++;
      if (clr_done === 1'b1) n_done++;
      @(negedge clk);
    end
    n_checks++;
    if (n_clr != 1 || n_done != 1) begin
      n_fail++;
      $display("FAIL merged_clear: got %0d clears %0d dones, expected 1 1", n_clr, n_done);
    end
  endtask

  task automatic test_same_addr();
    set_rq(0, 3'd4, 32'hAAAA_0000);
    set_rq(1, 3'd4, 32'hBBBB_1111);
    sb.push_back(mk(4'b0001, 3'd4, 32'hAAAA_0000));
    sb.push_back(mk(4'b0010, 3'd4, 32'hBBBB_1111));
    req = 4'b0011;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (rf_d_in !== 32'hBBBB_1111 || rf_en !== 8'b0) begin
      n_fail++;
      $display("FAIL same_addr_last: got d=%h rf_en=%h, expected bbbb1111 00", rf_d_in, rf_en);
    end
  endtask

  task automatic test_reset_midflight();
    int n_clr = 0;
    set_rq(2, 3'd1, 32'h1234_5678);
    req     = 4'b0100;
    clr_req = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0 || rf_en !== 8'b0) begin
      n_fail++;
      $display("FAIL midflight_drop: got ack=%b rf_en=%h, expected 0 0", ack, rf_en);
    end
    reset_n = 1'b1;
    req     = '0;
    clr_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rf_clear === 1'b1) n_clr++;
    end
    n_checks++;
    if (n_clr != 0) begin
      n_fail++;
      $display("FAIL midflight_clr_discard: got %0d clears, expected 0", n_clr);
    end
  endtask

`ifdef REGFILE_ARB_STATS_EN
  task automatic test_stats();
    mon_en = 1'b0;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got %0d, expected 0", stall_cnt);
    end
    req = 4'hF;
    for (int k = 0; k < 10; k++) @(negedge clk);
    n_checks++;
    if (stall_cnt !== 16'd10) begin
      n_fail++;
      $display("FAIL stats_10: got %0d, expected 10", stall_cnt);
    end
    for (int k = 0; k < 70000; k++) @(negedge clk);
    n_checks++;
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stats_sat: got %h, expected ffff", stall_cnt);
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    clr_req  = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear_priority();
    test_merged_clear();
    test_same_addr();
    test_reset_midflight();
`ifdef REGFILE_ARB_STATS_EN
    test_stats();
`endif
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending writes, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
